// File: rtl/timer_pkg.sv
// timer_pkg: state encoding, field limits and preset clamps shared by countdown_timer
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    function automatic logic [5:0] clamp_secs(input logic [5:0] v);
        return (v > SEC_MAX) ? SEC_MAX : v;
    endfunction
    function automatic logic [5:0] clamp_mins(input logic [5:0] v);
        return (v > MIN_MAX) ? MIN_MAX : v;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV enabled cycles
// ports: clk, reset (async, high), clear (zero count), enable (count/hold), tick (out)
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] count;
    assign tick = enable && !clear && (count == LAST);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else
            count <= clear ? '0 : !enable ? count : tick ? '0 : count + CW'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: HH:MM:SS countdown / count-up timer with load, start, stop and expiry
// ports: clk, reset (async, high), load/start/stop pulses, mode (0 down, 1 up),
//        hours_i/mins_i/secs_i preset, hours_o/mins_o/secs_o value, running, expired, done
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int HOUR_W    = 5,
    parameter int MAX_HOURS = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [HOUR_W-1:0] hours_i,
    input  logic [5:0]        mins_i,
    input  logic [5:0]        secs_i,
    output logic [HOUR_W-1:0] hours_o,
    output logic [5:0]        mins_o,
    output logic [5:0]        secs_o,
    output logic              running,
    output logic              expired,
    output logic              done
);
    localparam logic [HOUR_W-1:0] H_MAX = HOUR_W'(MAX_HOURS);
    timer_state_t      state, state_d;
    logic [HOUR_W-1:0] hours_d, dn_hours, up_hours;
    logic [5:0]        mins_d, secs_d, dn_mins, dn_secs, up_mins, up_secs;
    logic              mode_q, mode_d, done_d, tick;
    logic              s_zero, m_zero, s_top, m_top, h_top, v_zero, dn_zero, up_wrap;

    // load clears the prescaler so a fresh run always gets a full first second
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk(clk),
        .reset(reset),
        .clear(load),
        .enable(state == RUN),
        .tick(tick)
    );

    assign s_zero = secs_o == '0;
    assign m_zero = mins_o == '0;
    assign s_top  = secs_o == SEC_MAX;
    assign m_top  = mins_o == MIN_MAX;
    assign h_top  = hours_o >= H_MAX;
    assign v_zero = s_zero && m_zero && (hours_o == '0);

    // borrow chain; the hours guard keeps the field from ever wrapping below zero
    assign dn_secs  = s_zero ? SEC_MAX : secs_o - 6'd1;
    assign dn_mins  = !s_zero ? mins_o : m_zero ? MIN_MAX : mins_o - 6'd1;
    assign dn_hours = (s_zero && m_zero && hours_o != '0) ? hours_o - HOUR_W'(1) : hours_o;
    assign dn_zero  = (dn_hours == '0) && (dn_mins == '0) && (dn_secs == '0);

    // carry chain; MAX_HOURS:59:59 rolls over to zero
    assign up_secs  = s_top ? 6'd0 : secs_o + 6'd1;
    assign up_mins  = !s_top ? mins_o : m_top ? 6'd0 : mins_o + 6'd1;
    assign up_hours = !(s_top && m_top) ? hours_o : h_top ? '0 : hours_o + HOUR_W'(1);
    assign up_wrap  = s_top && m_top && h_top;

    assign running = state == RUN;
    assign expired = state == EXPIRED;

    always_comb begin
        state_d = state;
        hours_d = hours_o;
        mins_d  = mins_o;
        secs_d  = secs_o;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            hours_d = (hours_i > H_MAX) ? H_MAX : hours_i;
            mins_d  = clamp_mins(mins_i);
            secs_d  = clamp_secs(secs_i);
            mode_d  = mode;
        end else begin
            if (stop && state == RUN)
                state_d = PAUSE;
            else if (start && (state == IDLE || state == PAUSE) && (mode_q || !v_zero))
                state_d = RUN;
            // tick only fires in RUN, so a coincident stop still takes this step
            if (tick) begin
                hours_d = mode_q ? up_hours : dn_hours;
                mins_d  = mode_q ? up_mins : dn_mins;
                secs_d  = mode_q ? up_secs : dn_secs;
                done_d  = mode_q ? up_wrap : dn_zero;
                if (!mode_q && dn_zero)
                    state_d = EXPIRED;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            hours_o <= '0;
            mins_o  <= '0;
            secs_o  <= '0;
            mode_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            hours_o <= hours_d;
            mins_o  <= mins_d;
            secs_o  <= secs_d;
            mode_q  <= mode_d;
            done    <= done_d;
        end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with TICK_DIV=4, MAX_HOURS=23
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [4:0] hours_i = '0, hours_o;
    logic [5:0] mins_i = '0, secs_i = '0, mins_o, secs_o;
    logic       running, expired, done;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         bs;

    typedef struct {
        int          at;
        string       tag;
        logic [19:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t e;

    countdown_timer #(.TICK_DIV(4), .HOUR_W(5), .MAX_HOURS(23)) dut (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop), .mode(mode),
        .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
        .hours_o(hours_o), .mins_o(mins_o), .secs_o(secs_o),
        .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wire [19:0] obs = {hours_o, mins_o, secs_o, running, expired, done};

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d r%b e%b d%b, expected %0d:%0d:%0d r%b e%b d%b",
                     tag, got[19:15], got[14:9], got[8:3], got[2], got[1], got[0],
                     exp[19:15], exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [4:0] h,
                        input logic [5:0] m, input logic [5:0] s,
                        input logic r, input logic x, input logic d);
        sb.push_back('{at, tag, {h, m, s, r, x, d}});
    endtask

    // drive a set of inputs for exactly one sampling edge, then drop the pulses
    task automatic drive(input logic l, input logic st, input logic sp, input logic md,
                         input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        load = l; start = st; stop = sp; mode = md;
        hours_i = h; mins_i = m; secs_i = s;
        @(negedge clk);
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    always @(negedge clk)
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end

    initial begin
        #1 check("reset_async", obs, 20'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_idle", obs, 20'd0);

        // 1: 00:00:03 countdown to expiry
        push(cyc + 1, "t1_load", 0, 0, 3, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 3);
        bs = cyc + 1;
        push(bs,      "t1_start", 0, 0, 3, 1, 0, 0);
        push(bs + 3,  "t1_pre",   0, 0, 3, 1, 0, 0);
        push(bs + 4,  "t1_02",    0, 0, 2, 1, 0, 0);
        push(bs + 8,  "t1_01",    0, 0, 1, 1, 0, 0);
        push(bs + 12, "t1_exp",   0, 0, 0, 0, 1, 1);
        push(bs + 13, "t1_done1", 0, 0, 0, 0, 1, 0);
        push(bs + 20, "t1_hold",  0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (21) @(negedge clk);

        // 2: double borrow
        push(cyc + 1, "t2_load", 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        bs = cyc + 1;
        push(bs + 3, "t2_pre",    1, 0, 0, 1, 0, 0);
        push(bs + 4, "t2_borrow", 0, 59, 59, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);

        // 3: pause and resume keep the partial prescaler count
        push(cyc + 1, "t3_load", 0, 10, 20, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 10, 20);
        bs = cyc + 1;
        push(bs + 4, "t3_19", 0, 10, 19, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        push(bs + 6,  "t3_stop",  0, 10, 19, 0, 0, 0);
        push(bs + 26, "t3_pause", 0, 10, 19, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        bs = cyc + 1;
        push(bs,     "t3_resume", 0, 10, 19, 1, 0, 0);
        push(bs + 1, "t3_partial", 0, 10, 19, 1, 0, 0);
        push(bs + 2, "t3_18",     0, 10, 18, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // 4: clamp then count-up wrap
        push(cyc + 1, "t4_clamp", 23, 59, 59, 0, 0, 0);
        drive(1, 0, 0, 1, 30, 6'd63, 6'd63);
        bs = cyc + 1;
        push(bs,     "t4_start", 23, 59, 59, 1, 0, 0);
        push(bs + 4, "t4_wrap",  0, 0, 0, 1, 0, 1);
        push(bs + 5, "t4_after", 0, 0, 0, 1, 0, 0);
        push(bs + 8, "t4_up1",   0, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        push(cyc + 1, "t4_clamp2", 0, 59, 59, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 6'd60, 6'd59);

        // 5: zero countdown refuses to start; load wins over start/stop
        push(cyc + 1, "t5_zero", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        bs = cyc + 1;
        push(bs,     "t5_nostart", 0, 0, 0, 0, 0, 0);
        push(bs + 6, "t5_nodone",  0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        bs = cyc + 1;
        push(bs,     "t5_prio", 0, 5, 7, 0, 0, 0);
        push(bs + 4, "t5_idle", 0, 5, 7, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 5, 7);
        repeat (4) @(negedge clk);

        // 6: async reset mid-run, then start without load does nothing
        bs = cyc + 1;
        push(bs,     "t6_run",  0, 5, 7, 1, 0, 0);
        push(bs + 1, "t6_run1", 0, 5, 7, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t6_reset", obs, 20'd0);
        @(negedge clk);
        reset = 1'b0;
        bs = cyc + 1;
        push(bs,     "t6_nostart", 0, 0, 0, 0, 0, 0);
        push(bs + 5, "t6_still",   0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (7) @(negedge clk);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared, expected %h", e.tag, e.exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
